// File: rtl/inst_loader_pkg.sv
// Shared definitions for the boot-time instruction loader and instruction fetch.
// The S_SUM state exists only when INST_LOADER_CHECKSUM_EN is defined.
package inst_loader_pkg;

    localparam int INST_ADDR_W = 17;

    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
`ifdef INST_LOADER_CHECKSUM_EN
        S_SUM  = 3'd2,
`endif
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } loader_state_t;

    function automatic logic accepts_bytes(input loader_state_t s);
        logic ok;
        ok = (s == S_LEN) || (s == S_DATA);
`ifdef INST_LOADER_CHECKSUM_EN
        ok = ok || (s == S_SUM);
`endif
        return ok;
    endfunction

endpackage

// File: rtl/inst_loader_if.sv
// Byte-stream input and instruction-BRAM write port of the loader.
// master = byte source / memory side, slave = the loader itself.
interface inst_loader_if #(
    parameter int ADDR_W = inst_loader_pkg::INST_ADDR_W
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/byte_word_assembler.sv
// Packs bytes MSB-first into 32-bit words; word/word_done are combinational so
// the owner can act on the completed word in the same cycle as the 4th byte.
module byte_word_assembler (
    input  logic        clk,
    input  logic        rstn,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_done
);
    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] shift_q, shift_d;

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clr) begin
            cnt_d = '0;
        end else if (byte_valid) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = {shift_q[15:0], byte_in};
        end
    end

    assign word      = {shift_q, byte_in};
    assign word_done = byte_valid && !clr && (cnt_q == 2'd3);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end
endmodule

// File: rtl/inst_loader.sv
// Boot loader: 32-bit big-endian length, then payload words written to instruction BRAM.
// Optional trailing XOR checksum byte when INST_LOADER_CHECKSUM_EN is defined.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int          ADDR_W    = INST_ADDR_W,
    parameter int unsigned MAX_WORDS = 2 ** ADDR_W
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         reload,
    inst_loader_if.slave bus,
    output logic         done,
    output logic         error
);
    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       remaining_q, remaining_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              fire, asm_valid, word_done;
    logic [31:0]       asm_word;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    assign bus.rx_ready = accepts_bytes(state_q) && !reload;
    assign fire         = bus.rx_valid && bus.rx_ready;
    // After the last word completes the state lingers in S_DATA for the write cycle;
    // stray bytes then must not start another word.
    assign asm_valid    = fire && ((state_q == S_LEN) ||
                                   ((state_q == S_DATA) && (remaining_q != '0)));

    byte_word_assembler u_asm (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (reload),
        .byte_valid(asm_valid),
        .byte_in   (bus.rx_data),
        .word      (asm_word),
        .word_done (word_done)
    );

    always_comb begin
        state_d     = state_q;
        waddr_d     = waddr_q;
        remaining_d = remaining_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        if (reload) begin
            state_d     = S_LEN;
            waddr_d     = '0;
            remaining_d = '0;
`ifdef INST_LOADER_CHECKSUM_EN
            sum_d       = '0;
`endif
        end else begin
            case (state_q)
                S_LEN: begin
                    if (word_done) begin
                        if (asm_word == '0) begin
`ifdef INST_LOADER_CHECKSUM_EN
                            state_d = S_SUM;
`else
                            state_d = S_DONE;
`endif
                        end else if (asm_word > MAX_WORDS) begin
                            state_d = S_ERR;
                        end else begin
                            state_d     = S_DATA;
                            waddr_d     = '0;
                            remaining_d = asm_word;
                        end
`ifdef INST_LOADER_CHECKSUM_EN
                        sum_d = '0;
`endif
                    end
                end
                S_DATA: begin
`ifdef INST_LOADER_CHECKSUM_EN
                    if (asm_valid) begin
                        sum_d = sum_q ^ bus.rx_data;
                    end
`endif
                    if (word_done) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = waddr_q;
                        mem_wdata_d = asm_word;
                        waddr_d     = waddr_q + 1'b1;
                        remaining_d = remaining_q - 32'd1;
`ifdef INST_LOADER_CHECKSUM_EN
                        if (remaining_q == 32'd1) begin
                            state_d = S_SUM;
                        end
`endif
                    end
`ifndef INST_LOADER_CHECKSUM_EN
                    else if (remaining_q == '0) begin
                        state_d = S_DONE;
                    end
`endif
                end
`ifdef INST_LOADER_CHECKSUM_EN
                S_SUM: begin
                    if (fire) begin
                        state_d = (bus.rx_data == sum_q) ? S_DONE : S_ERR;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_LEN;
            waddr_q     <= '0;
            remaining_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            waddr_q     <= waddr_d;
            remaining_q <= remaining_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
`ifdef INST_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign done          = (state_q == S_DONE);
    assign error         = (state_q == S_ERR);
endmodule

// File: tb/tb_inst_loader.sv
// Randomized self-checking bench for inst_loader against a stream-level reference model.
`timescale 1ns/1ps
module tb_inst_loader;
    localparam int ADDR_W    = 4;
    localparam int MAX_WORDS = 1 << ADDR_W;

    typedef logic [7:0] byte_q_t[$];

    logic clk    = 1'b0;
    logic rstn   = 1'b0;
    logic reload = 1'b0;
    logic done, error;

    inst_loader_if #(.ADDR_W(ADDR_W)) bus ();

    inst_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .reload(reload),
        .bus   (bus),
        .done  (done),
        .error (error)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write log and done/error rise times, sampled mid-cycle.
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];
    longint            wr_cyc_q[$];
    longint            done_rise = -1;
    longint            err_rise  = -1;
    logic              done_prev = 1'b0;
    logic              err_prev  = 1'b0;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wr_addr_q.push_back(bus.mem_addr);
            wr_data_q.push_back(bus.mem_wdata);
            wr_cyc_q.push_back(cyc);
        end
        if (done === 1'b1 && done_prev !== 1'b1) done_rise <= cyc;
        if (error === 1'b1 && err_prev !== 1'b1) err_rise <= cyc;
        done_prev <= done;
        err_prev  <= error;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic byte_q_t rand_bytes(input int n);
        byte_q_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    // Entered and left just after a rising edge; e = cycle index of the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap_mode, output longint e);
        int   idle;
        logic rdy;
        idle = (gap_mode == 2) ? 1 : ((gap_mode == 1) ? int'($urandom_range(0, 2)) : 0);
        if (idle > 0) begin
            bus.rx_valid = 1'b0;
            repeat (idle) @(posedge clk);
            #1;
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        e = -1;
        for (int t = 0; t < 20 && e < 0; t++) begin
            @(negedge clk);
            rdy = bus.rx_ready;
            @(posedge clk);
            #1;
            if (rdy === 1'b1) e = cyc;
        end
        if (e < 0) check_val("rx_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic pulse_reload();
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'($urandom);
        reload       = 1'b1;
        @(negedge clk);
        check_val("reload_blocks_ready", 64'(bus.rx_ready), 64'd0);
        @(posedge clk);
        #1;
        reload       = 1'b0;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_len(input logic [31:0] len, input int gap_mode, output longint e);
        for (int i = 0; i < 4; i++) send_byte(len[31-8*i -: 8], gap_mode, e);
    endtask

    // Reference: words = payload packed big-endian to addresses 0..len-1; fault if len > MAX_WORDS
    // (or checksum mismatch); done/error timing derived from byte acceptance cycles.
    task automatic run_load(input string name, input logic [31:0] len, input byte_q_t pl,
                            input int gap_mode, input bit bad_sum);
        int         n0, nw;
        bit         exp_err;
        longint     e, e_len4, exp_evt;
        longint     exp_wcyc[$];
        logic [7:0] sum;
        logic [31:0] exp_word;

        pulse_reload();
        n0 = wr_addr_q.size();
        send_len(len, gap_mode, e);
        e_len4  = e;
        exp_err = (len > 32'(MAX_WORDS));
        nw      = exp_err ? 0 : int'(len);
        sum     = 8'h00;
        exp_evt = e_len4;
        if (!exp_err) begin
            for (int i = 0; i < 4 * nw; i++) begin
                send_byte(pl[i], gap_mode, e);
                sum ^= pl[i];
                if (i % 4 == 3) exp_wcyc.push_back(e);
            end
`ifdef INST_LOADER_CHECKSUM_EN
            send_byte(bad_sum ? (sum ^ 8'h01) : sum, gap_mode, e);
            exp_evt = e;
            exp_err = bad_sum;
`else
            if (nw > 0) exp_evt = exp_wcyc[nw-1] + 1;
`endif
        end
        bus.rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        check_val({name, "_nwrites"}, 64'(wr_addr_q.size() - n0), 64'(nw));
        for (int k = 0; k < nw && (n0 + k) < wr_addr_q.size(); k++) begin
            exp_word = {pl[4*k], pl[4*k+1], pl[4*k+2], pl[4*k+3]};
            check_val($sformatf("%s_addr%0d", name, k), 64'(wr_addr_q[n0+k]), 64'(k % MAX_WORDS));
            check_val($sformatf("%s_data%0d", name, k), 64'(wr_data_q[n0+k]), 64'(exp_word));
            check_val($sformatf("%s_wcyc%0d", name, k), 64'(wr_cyc_q[n0+k]), 64'(exp_wcyc[k]));
        end
        check_val({name, "_done"}, 64'(done), exp_err ? 64'd0 : 64'd1);
        check_val({name, "_error"}, 64'(error), exp_err ? 64'd1 : 64'd0);
        if (exp_err) check_val({name, "_err_cycle"}, 64'(err_rise), 64'(exp_evt));
        else         check_val({name, "_done_cycle"}, 64'(done_rise), 64'(exp_evt));
        check_val({name, "_ready_off"}, 64'(bus.rx_ready), 64'd0);
        $display("load %s len=0x%08h words=%0d gap=%0d bad_sum=%0d expect_%s",
                 name, len, nw, gap_mode, bad_sum, exp_err ? "error" : "done");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t none;
        byte_q_t pl;
        longint  e;
        int      lens[6];

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_rx_ready", 64'(bus.rx_ready), 64'd1);
        check_val("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check_val("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        check_val("rst_mem_we", 64'(bus.mem_we), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_error", 64'(error), 64'd0);

        pl = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        run_load("two_words", 32'd2, pl, 0, 1'b0);
        run_load("len_zero", 32'd0, none, 0, 1'b0);
        run_load("too_long", 32'h0002_0001, none, 0, 1'b0);
        run_load("toggle3", 32'd3, rand_bytes(12), 2, 1'b0);

        // Abort after 6 payload bytes; the fresh stream must not see the leftovers.
        pulse_reload();
        send_len(32'd2, 0, e);
        pl = rand_bytes(6);
        for (int i = 0; i < 6; i++) send_byte(pl[i], 0, e);
        bus.rx_valid = 1'b0;
        pl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_load("reload_restart", 32'd1, pl, 0, 1'b0);

        // Asynchronous reset landing in the write cycle of a word.
        pulse_reload();
        send_len(32'd2, 0, e);
        pl = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        for (int i = 0; i < 4; i++) send_byte(pl[i], 0, e);
        bus.rx_valid = 1'b0;
        check_val("pre_rst_mem_we", 64'(bus.mem_we), 64'd1);
        #2 rstn = 1'b0;
        #1;
        check_val("async_rst_rx_ready", 64'(bus.rx_ready), 64'd1);
        check_val("async_rst_mem_we", 64'(bus.mem_we), 64'd0);
        check_val("async_rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check_val("async_rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        check_val("async_rst_done", 64'(done), 64'd0);
        check_val("async_rst_error", 64'(error), 64'd0);
        $display("load async_reset mid-load");
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        lens = '{MAX_WORDS, MAX_WORDS + 1, 1, 0, 0, 0};
        lens[3] = int'($urandom_range(1, MAX_WORDS));
        lens[4] = int'($urandom_range(1, MAX_WORDS));
        lens[5] = int'($urandom_range(0, MAX_WORDS + 1));
        for (int r = 0; r < 6; r++) begin
            run_load($sformatf("rand%0d", r), 32'(lens[r]), rand_bytes(4 * lens[r]),
                     int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

`ifdef INST_LOADER_CHECKSUM_EN
        pl = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load("sum_ok", 32'd1, pl, 0, 1'b0);
        run_load("sum_bad", 32'd1, pl, 0, 1'b1);
        run_load("sum_len0", 32'd0, none, 1, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_loader.md
# inst_loader

Boot-time program loader upstream of instruction fetch. It consumes a byte stream from the UART receiver, assembles big-endian 32-bit instruction words, and writes them sequentially into the instruction BRAM that fetch later reads by word address. It then raises `done`, which releases the core from reset.

## Interface
Parameters:
- `ADDR_W`, 17, instruction-memory word-address width (matches fetch `inst_addr`).
- `MAX_WORDS`, 2**ADDR_W, largest accepted program length in words.

Ports:
- `clk`  in  1  system clock.
- `rstn`  in  1  reset. **Asynchronous, active-low.**
- `reload`  in  1  single-cycle pulse; aborts any state and restarts at length reception.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `mem_addr`  out  ADDR_W  instruction BRAM word address (registered).
- `mem_wdata`  out  32  instruction word (registered).
- `mem_we`  out  1  one-cycle write strobe.
- `done`  out  1  program fully loaded; held until `reload` or reset.
- `error`  out  1  length or checksum fault; held until `reload` or reset.

## Operation
- States: `S_LEN`, `S_DATA`, `S_SUM` (only with the macro), `S_DONE`, `S_ERR`.
- A byte is accepted on a posedge with `rx_valid && rx_ready`.
- `rx_ready = (state is S_LEN, S_DATA or S_SUM) && !reload`.
- **`S_LEN`**
  - Shifts in 4 bytes MSB-first into 32-bit `len`.
  - After the 4th byte:
    - `len == 0` goes to `S_SUM` if enabled, else `S_DONE`.
    - `len > MAX_WORDS` goes to `S_ERR`.
    - Otherwise goes to `S_DATA`, with word address = 0 and remaining = `len`.
- **`S_DATA`**
  - A 2-bit byte counter shifts bytes MSB-first into the word buffer.
  - On the 4th byte, the next cycle presents `mem_wdata` = assembled word, `mem_addr` = current word address, `mem_we` = 1.
  - The word address then increments and remaining decrements.
  - When remaining reaches 0, goes to `S_SUM` if enabled, else `S_DONE`.
- Byte ordering: first byte → `[31:24]`.
- Address arithmetic is ADDR_W-bit. With `len == MAX_WORDS`, the final write is to `MAX_WORDS-1`. The post-increment wrap to 0 is harmless because no further write occurs.
- **`S_DONE`**: `done` = 1, `rx_ready` = 0.
- **`S_ERR`**: `error` = 1, `rx_ready` = 0, no writes.
- **`reload`**
  - Highest priority: the next state is `S_LEN` and all counters clear.
  - A coincident byte is not accepted (`rx_ready` is 0).
  - A write strobe already registered still completes that cycle.
- BRAM contents are never cleared by reset or `reload`.

## Timing
- Reset values:
  - `rx_ready` = 1 (state `S_LEN`).
  - `mem_addr` = 0, `mem_wdata` = 0, `mem_we` = 0.
  - `done` = 0, `error` = 0.
- Write latency: `mem_we` is high exactly 1 cycle after the 4th byte of a word is accepted, for 1 cycle.
- Without the macro, `done` rises 1 cycle after the final `mem_we`. For `len == 0`, it rises 1 cycle after the 4th length byte.
- `error` rises 1 cycle after the offending byte.
- Back-to-back bytes (`rx_valid` held high) are accepted every cycle, so a word is written every 4 cycles.
- An asynchronous reset mid-load forces state `S_LEN` immediately and deasserts `mem_we` immediately.

## Configuration
- `INST_LOADER_CHECKSUM_EN` defined:
  - An 8-bit XOR accumulates over all payload bytes (length bytes excluded).
  - `S_SUM` accepts one trailing byte. It goes to `S_DONE` on match and to `S_ERR` on mismatch.
  - Words already written stay in memory.
  - `done` rises 1 cycle after the checksum byte.
- Not defined: `S_SUM`, the accumulator and the trailing byte are absent.

## Structure
- The shared package holds the state enum (`loader_state_t`) and the `INST_ADDR_W = 17` constant also used by fetch.
- One sub-module, `byte_word_assembler`: 4-byte shift register with byte counter and word-complete pulse, reset by `reload`.

## Test plan
- Length bytes 00 00 00 02, then 12 34 56 78 9A BC DE F0 → writes addr 0 = 0x12345678 and addr 1 = 0x9ABCDEF0; `done` = 1 one cycle after the second `mem_we`.
- Length 00 00 00 00 → no `mem_we`; `done` = 1 one cycle after the 4th byte.
- Length 00 02 00 01 (> MAX_WORDS) → `error` = 1, `rx_ready` = 0, no writes.
- `rx_valid` toggling 1/0 every cycle during a 3-word load → writes at addr 0, 1, 2 with correct data; no spurious `mem_we`.
- `reload` after 6 payload bytes, then a fresh 1-word stream AA BB CC DD → single write addr 0 = 0xAABBCCDD; `rstn` low mid-word → all outputs at reset values.
- With `INST_LOADER_CHECKSUM_EN`: payload 01 02 03 04 + 04 → `done`; + 05 → `error`.
